uart_rsp_tx: RTL and testbench
==============================

UART_RSP_TX -- requirements
Module: uart_rsp_tx

Interface
REQ-001 SHALL have parameter BAUD_CNT_MAX_TX, default 868, giving sys_clk cycles per UART bit (115200 baud at 100 MHz).
REQ-002 SHALL have parameter ADDR_BYTES, default 4, giving the number of address bytes per packet.
REQ-003 SHALL have parameter DATA_BYTES, default 16, giving the number of data bytes per packet (one 8-beat x16 DDR2 burst).
REQ-004 sys_clk  input  1  single clock; all logic is clocked on its rising edge.
REQ-005 sys_rst  input  1  asynchronous, active-high reset.
REQ-006 rsp_valid  input  1  read-response packet available.
REQ-007 rsp_ready  output  1  block can accept a packet.
REQ-008 rsp_addr  input  8*ADDR_BYTES  read address echoed to the host.
REQ-009 rsp_data  input  8*DATA_BYTES  read burst data.
REQ-010 uart_tx  output  1  serial line, 8N1, LSB first, idles high.
REQ-011 tx_busy  output  1  high while a packet is being sent.
REQ-012 rsp_done  output  1  one-cycle pulse when a packet completes.

Function
REQ-013 Packet byte order SHALL be: 0x02 header; address MSB byte first; data with rsp_data[8*DATA_BYTES-1 -: 8] first; optional checksum (REQ-028); 0xFF tail.
REQ-014 States SHALL be IDLE, LOAD, START, DATA, STOP, NEXT.
- IDLE->LOAD on rsp_valid&&rsp_ready.
- LOAD->START.
- START->DATA after one bit time.
- DATA->STOP after 8 bit times.
- STOP->NEXT after one bit time.
- NEXT->START if more bytes remain, else ->IDLE.
REQ-015 rsp_ready SHALL be high only in IDLE.
REQ-016 rsp_addr and rsp_data SHALL be captured on the accepting edge; later input changes SHALL NOT affect the packet in flight.
REQ-017 rsp_valid while not ready SHALL be ignored; the source holds its packet until it is accepted.
REQ-018 Each bit time SHALL be exactly BAUD_CNT_MAX_TX cycles, counted 0..BAUD_CNT_MAX_TX-1; the counter SHALL clear at every bit boundary.
REQ-019 The start bit SHALL be driven low on the cycle after LOAD.
REQ-020 Bytes SHALL be sent back to back with no idle bits between the stop bit and the next start bit.
REQ-021 The byte index counter SHALL be wide enough for ADDR_BYTES+DATA_BYTES+3 and SHALL NOT wrap within a packet.
REQ-022 rsp_done SHALL pulse on the cycle the FSM enters IDLE from NEXT; rsp_ready SHALL rise on that same cycle.
REQ-023 A new packet accepted on that same cycle SHALL start normally, giving a minimum packet-to-packet gap of one LOAD cycle.
REQ-024 tx_busy SHALL be high in every state except IDLE.
REQ-025 uart_tx SHALL be registered and glitch-free.

Reset
REQ-026 sys_rst SHALL force, asynchronously and including mid-packet: state=IDLE, uart_tx=1, rsp_ready=1, tx_busy=0, rsp_done=0, all counters=0, capture registers=0.
REQ-027 A packet aborted by reset SHALL NOT be resumed, and rsp_done SHALL NOT pulse for it.

Configuration
REQ-028 With UART_RSP_CHKSUM_EN defined:
- one byte SHALL be inserted before the 0xFF tail;
- its value is the XOR of the header, address and data bytes;
- a packet is ADDR_BYTES+DATA_BYTES+3 bytes.
REQ-029 Without UART_RSP_CHKSUM_EN:
- no checksum byte and no checksum logic;
- a packet is ADDR_BYTES+DATA_BYTES+2 bytes (22 with defaults).

Structure
REQ-030 Shared package uart_pkt_pkg SHALL hold:
- CMD_WR=8'h01, CMD_RD=8'h02, PKT_TAIL=8'hFF;
- default ADDR_BYTES and DATA_BYTES;
- the FSM state enum.
The matching receive-side command parser SHALL use the same package.
REQ-031 Sub-module uart_byte_tx SHALL hold:
- the baud counter, bit counter and shift register;
- a start/busy/done handshake.
uart_rsp_tx SHALL hold the packet FSM, byte mux and checksum.

Verification (BAUD_CNT_MAX_TX=56, no macro unless stated)
REQ-032 rsp_addr=0x00000000, rsp_data=0x112233445566778899AABBCCDDEE1122, one valid pulse -> line decodes 02 00 00 00 00 11 22 33 44 55 66 77 88 99 AA BB CC DD EE 11 22 FF; rsp_done pulses 22*10*56+1 = 12321 cycles after acceptance.
REQ-033 Each start-bit low width and each data-bit width measured -> exactly 560 ns (56 cycles); uart_tx stays high between packets.
REQ-034 rsp_valid held high continuously for two packets; inputs changed mid-packet -> first packet unaffected; second packet begins one cycle after rsp_done; rsp_ready low throughout each packet.
REQ-035 sys_rst asserted during data byte 7 -> uart_tx=1 and tx_busy=0 immediately, no rsp_done pulse; next packet is complete and correct.
REQ-036 UART_RSP_CHKSUM_EN defined, rsp_addr=0x00000010, rsp_data all 0xA5 -> 23 bytes, checksum byte = 0x12 before FF.
REQ-037 rsp_data all 0x00 -> every data byte 00, framing intact, stop bits high.

Source files
------------

// File: rtl/uart_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkt_pkg
// Brief    : Packet constants, default payload sizes and the packet FSM state
//            type shared by the UART response transmitter and command parser.
// Revision : 1.0
// ============================================================================
package uart_pkt_pkg;

    localparam logic [7:0] CMD_WR   = 8'h01;
    localparam logic [7:0] CMD_RD   = 8'h02;
    localparam logic [7:0] PKT_TAIL = 8'hFF;

    localparam int DEF_ADDR_BYTES = 4;
    localparam int DEF_DATA_BYTES = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4,
        ST_NEXT  = 3'd5
    } pkt_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rsp_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rsp_tx_if
// Brief    : Valid/ready read-response channel feeding the UART transmitter.
// Revision : 1.0
// ============================================================================
interface uart_rsp_tx_if
    import uart_pkt_pkg::*;
#(
    parameter int ADDR_BYTES = DEF_ADDR_BYTES,
    parameter int DATA_BYTES = DEF_DATA_BYTES
);
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [8*ADDR_BYTES-1:0]   rsp_addr;
    logic [8*DATA_BYTES-1:0]   rsp_data;

    modport master (output rsp_valid, output rsp_addr, output rsp_data, input rsp_ready);
    modport slave  (input rsp_valid, input rsp_addr, input rsp_data, output rsp_ready);
endinterface
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_tx
// Brief    : 8N1 byte serialiser with baud/bit counters; a start on the done
//            cycle reloads immediately so frames can run back to back.
// Revision : 1.0
// ============================================================================
module uart_byte_tx #(
    parameter int BAUD_CNT_MAX = 868
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       bit_tick_o,
    output logic [3:0] bit_idx_o,
    output logic       stop_pre_o
);
    localparam int c_CNT_W = (BAUD_CNT_MAX > 2) ? $clog2(BAUD_CNT_MAX) : 1;

    logic [c_CNT_W-1:0] r_baud_q;
    logic [3:0]         r_bit_q;
    logic [8:0]         r_shift_q;
    logic               r_tx_q;
    logic               r_busy_q;

    logic w_bit_tick;
    logic w_done;

    assign w_bit_tick = r_busy_q && (r_baud_q == c_CNT_W'(BAUD_CNT_MAX - 1));
    assign w_done     = w_bit_tick && (r_bit_q == 4'd9);

    assign tx_o       = r_tx_q;
    assign busy_o     = r_busy_q;
    assign done_o     = w_done;
    assign bit_tick_o = w_bit_tick;
    assign bit_idx_o  = r_bit_q;
    // One cycle ahead of the stop-bit end, so the packet FSM can stage the next byte.
    assign stop_pre_o = r_busy_q && (r_bit_q == 4'd9) && (r_baud_q == c_CNT_W'(BAUD_CNT_MAX - 2));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_baud_q  <= '0;
            r_bit_q   <= '0;
            r_shift_q <= '0;
            r_tx_q    <= 1'b1;
            r_busy_q  <= 1'b0;
        end else if (start_i) begin
            r_baud_q  <= '0;
            r_bit_q   <= '0;
            r_shift_q <= {1'b1, data_i};
            r_tx_q    <= 1'b0;
            r_busy_q  <= 1'b1;
        end else if (r_busy_q) begin
            if (w_bit_tick) begin
                r_baud_q <= '0;
                if (w_done) begin
                    r_bit_q  <= '0;
                    r_tx_q   <= 1'b1;
                    r_busy_q <= 1'b0;
                end else begin
                    r_bit_q   <= r_bit_q + 4'd1;
                    r_tx_q    <= r_shift_q[0];
                    r_shift_q <= {1'b1, r_shift_q[8:1]};
                end
            end else begin
                r_baud_q <= r_baud_q + c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rsp_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rsp_tx
// Brief    : Serialises a read response as 02 | addr | data | [chk] | FF over
//            8N1 UART. Optional XOR checksum byte: UART_RSP_CHKSUM_EN.
// Revision : 1.0
// ============================================================================
module uart_rsp_tx
    import uart_pkt_pkg::*;
#(
    parameter int BAUD_CNT_MAX_TX = 868,
    parameter int ADDR_BYTES      = DEF_ADDR_BYTES,
    parameter int DATA_BYTES      = DEF_DATA_BYTES
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    uart_rsp_tx_if.slave rsp,
    output logic         uart_tx,
    output logic         tx_busy,
    output logic         rsp_done
);
    localparam int c_PAYLOAD_END = ADDR_BYTES + DATA_BYTES;
`ifdef UART_RSP_CHKSUM_EN
    localparam int c_PKT_BYTES   = c_PAYLOAD_END + 3;
`else
    localparam int c_PKT_BYTES   = c_PAYLOAD_END + 2;
`endif
    localparam int c_IDX_W       = $clog2(c_PAYLOAD_END + 3 + 1);
    localparam int c_LAST        = c_PKT_BYTES - 1;

    pkt_state_e              r_state_q;
    logic [c_IDX_W-1:0]      r_idx_q;
    logic [7:0]              r_byte_q;
    logic                    r_start_q;
    logic                    r_ready_q;
    logic                    r_busy_q;
    logic                    r_done_q;
    logic [8*ADDR_BYTES-1:0] r_addr_q;
    logic [8*DATA_BYTES-1:0] r_data_q;
`ifdef UART_RSP_CHKSUM_EN
    logic [7:0]              r_chk_q;
`endif

    logic [c_IDX_W-1:0] w_idx_d;
    int                 w_idx_int;
    logic [7:0]         w_byte_d;
    logic               w_byte_busy;
    logic               w_byte_done;
    logic               w_bit_tick;
    logic [3:0]         w_bit_idx;
    logic               w_stop_pre;

    uart_byte_tx #(
        .BAUD_CNT_MAX (BAUD_CNT_MAX_TX)
    ) u_byte_tx (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .start_i    (r_start_q),
        .data_i     (r_byte_q),
        .tx_o       (uart_tx),
        .busy_o     (w_byte_busy),
        .done_o     (w_byte_done),
        .bit_tick_o (w_bit_tick),
        .bit_idx_o  (w_bit_idx),
        .stop_pre_o (w_stop_pre)
    );

    assign rsp.rsp_ready = r_ready_q;
    assign tx_busy       = r_busy_q;
    assign rsp_done      = r_done_q;

    // Byte following the one on the line; the header is loaded directly on accept.
    always_comb begin
        w_idx_d   = r_idx_q + c_IDX_W'(1);
        w_idx_int = int'(w_idx_d);
        w_byte_d  = PKT_TAIL;
        if (w_idx_int >= 1 && w_idx_int <= ADDR_BYTES)
            w_byte_d = 8'(r_addr_q >> (8 * (ADDR_BYTES - w_idx_int)));
        else if (w_idx_int > ADDR_BYTES && w_idx_int <= c_PAYLOAD_END)
            w_byte_d = 8'(r_data_q >> (8 * (c_PAYLOAD_END - w_idx_int)));
`ifdef UART_RSP_CHKSUM_EN
        else if (w_idx_int == c_PAYLOAD_END + 1)
            w_byte_d = r_chk_q;
`endif
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state_q <= ST_IDLE;
            r_idx_q   <= '0;
            r_byte_q  <= '0;
            r_start_q <= 1'b0;
            r_ready_q <= 1'b1;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
            r_addr_q  <= '0;
            r_data_q  <= '0;
`ifdef UART_RSP_CHKSUM_EN
            r_chk_q   <= '0;
`endif
        end else begin
            r_start_q <= 1'b0;
            r_done_q  <= 1'b0;
            case (r_state_q)
                ST_IDLE: begin
                    if (rsp.rsp_valid && r_ready_q) begin
                        r_state_q <= ST_LOAD;
                        r_ready_q <= 1'b0;
                        r_busy_q  <= 1'b1;
                        r_addr_q  <= rsp.rsp_addr;
                        r_data_q  <= rsp.rsp_data;
                        r_idx_q   <= '0;
                        r_byte_q  <= CMD_RD;
                        r_start_q <= 1'b1;
`ifdef UART_RSP_CHKSUM_EN
                        r_chk_q   <= CMD_RD;
`endif
                    end
                end
                ST_LOAD: r_state_q <= ST_START;
                ST_START: begin
                    if (w_byte_busy && w_bit_tick)
                        r_state_q <= ST_DATA;
                end
                ST_DATA: begin
                    if (w_bit_tick && w_bit_idx == 4'd8)
                        r_state_q <= ST_STOP;
                end
                ST_STOP: begin
                    if (w_stop_pre) begin
                        r_state_q <= ST_NEXT;
                        if (r_idx_q != c_IDX_W'(c_LAST)) begin
                            r_idx_q   <= w_idx_d;
                            r_byte_q  <= w_byte_d;
                            r_start_q <= 1'b1;
`ifdef UART_RSP_CHKSUM_EN
                            if (w_idx_int <= c_PAYLOAD_END)
                                r_chk_q <= r_chk_q ^ w_byte_d;
`endif
                        end
                    end
                end
                ST_NEXT: begin
                    // A pending start means another byte was staged in STOP.
                    if (w_byte_done) begin
                        if (r_start_q) begin
                            r_state_q <= ST_START;
                        end else begin
                            r_state_q <= ST_IDLE;
                            r_idx_q   <= '0;
                            r_ready_q <= 1'b1;
                            r_busy_q  <= 1'b0;
                            r_done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state_q <= ST_IDLE;
                    r_ready_q <= 1'b1;
                    r_busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rsp_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_rsp_tx
// Brief    : Self-checking bench: line decoder, packet model and timing scoreboard.
// Revision : 1.0
// ============================================================================
module tb_uart_rsp_tx;
    import uart_pkt_pkg::*;

    localparam int BAUD    = 56;
    localparam int AB      = 4;
    localparam int DB      = 16;
    localparam int FRAME_T = 10 * BAUD;
`ifdef UART_RSP_CHKSUM_EN
    localparam int NB = AB + DB + 3;
`else
    localparam int NB = AB + DB + 2;
`endif
    localparam int TMO = 20000;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic uart_tx, tx_busy, rsp_done;

    uart_rsp_tx_if #(.ADDR_BYTES(AB), .DATA_BYTES(DB)) rsp_if ();

    uart_rsp_tx #(
        .BAUD_CNT_MAX_TX (BAUD),
        .ADDR_BYTES      (AB),
        .DATA_BYTES      (DB)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .rsp      (rsp_if),
        .uart_tx  (uart_tx),
        .tx_busy  (tx_busy),
        .rsp_done (rsp_done)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_bytes[$];
    int         exp_starts[$];
    int         exp_done[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: actual event with nothing expected (cycle %0d)", name, cyc);
    endtask

    // Reference packet built from the byte-order rules
    task automatic push_model(input logic [31:0] a, input logic [127:0] d);
        logic [7:0] x, b;
        exp_bytes.push_back(CMD_RD);
        x = CMD_RD;
        for (int i = AB - 1; i >= 0; i--) begin
            b = 8'(a >> (8 * i));
            exp_bytes.push_back(b);
            x = x ^ b;
        end
        for (int i = DB - 1; i >= 0; i--) begin
            b = 8'(d >> (8 * i));
            exp_bytes.push_back(b);
            x = x ^ b;
        end
`ifdef UART_RSP_CHKSUM_EN
        exp_bytes.push_back(x);
`endif
        exp_bytes.push_back(PKT_TAIL);
    endtask

    task automatic push_stream(input logic [8*23-1:0] s, input int n);
        for (int i = 0; i < n; i++) exp_bytes.push_back(8'(s >> (8 * (n - 1 - i))));
    endtask

    // Acceptance, handshake and idle-line monitor
    initial forever begin
        @(negedge sys_clk);
        if (!sys_rst) begin
            if (rsp_if.rsp_valid && rsp_if.rsp_ready) begin
                for (int k = 0; k < NB; k++) exp_starts.push_back(cyc + 2 + k * FRAME_T);
                exp_done.push_back(cyc + 2 + NB * FRAME_T);
            end
            chk("ready_vs_busy", rsp_if.rsp_ready, !tx_busy);
            if (!tx_busy) chk("idle_line_high", uart_tx, 1'b1);
            if (rsp_done) begin
                if (exp_done.size() == 0) fail_now("unexpected_done");
                else chk("done_cycle", cyc, exp_done.pop_front());
            end
        end
    end

    // Line decoder: mid-bit sampling plus per-bit stability over every cycle
    initial begin
        bit         dec_on = 1'b0;
        bit         glitch = 1'b0;
        int         cnt = 0;
        logic       ref_bit = 1'b1;
        logic [9:0] bits = '0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                dec_on = 1'b0;
            end else begin
                if (!dec_on && uart_tx == 1'b0) begin
                    dec_on = 1'b1;
                    cnt    = 0;
                    glitch = 1'b0;
                    if (exp_starts.size() == 0) fail_now("unexpected_frame");
                    else chk("frame_start_cycle", cyc, exp_starts.pop_front());
                end
                if (dec_on) begin
                    if (cnt % BAUD == 0) ref_bit = uart_tx;
                    else if (uart_tx !== ref_bit) glitch = 1'b1;
                    if (cnt % BAUD == BAUD / 2) bits[cnt / BAUD] = uart_tx;
                    cnt++;
                    if (cnt == FRAME_T) begin
                        dec_on = 1'b0;
                        chk("start_bit", bits[0], 1'b0);
                        chk("stop_bit", bits[9], 1'b1);
                        chk("bit_width_stable", glitch, 1'b0);
                        if (exp_bytes.size() == 0) fail_now("unexpected_byte");
                        else chk("rx_byte", bits[8:1], exp_bytes.pop_front());
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [127:0] d);
        int t = 0;
        while (rsp_if.rsp_ready !== 1'b1 && t < TMO) begin
            @(posedge sys_clk); #1;
            t++;
        end
        if (t >= TMO) chk("ready_timeout", 1'b1, 1'b0);
        rsp_if.rsp_valid = 1'b1;
        rsp_if.rsp_addr  = a;
        rsp_if.rsp_data  = d;
        @(posedge sys_clk); #1;
        rsp_if.rsp_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_done.size() != 0 || tx_busy) && t < TMO) begin
            @(posedge sys_clk); #1;
            t++;
        end
        chk("drain_timeout", (t >= TMO), 1'b0);
    endtask

    typedef struct {
        logic [31:0]     addr;
        logic [127:0]    data;
        logic [8*23-1:0] stream;
    } vec_t;

    vec_t tbl[3];

    initial begin
        logic [31:0]  a1, a2;
        logic [127:0] d1, d2;
        int           t;

`ifdef UART_RSP_CHKSUM_EN
        tbl[0] = '{32'h00000000, 128'h112233445566778899AABBCCDDEE1122,
                   184'h0200000000112233445566778899AABBCCDDEE1122CEFF};
        tbl[1] = '{32'h00000010, {16{8'hA5}},
                   184'h0200000010A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A512FF};
        tbl[2] = '{32'hDEADBEEF, 128'h0,
                   184'h02DEADBEEF0000000000000000000000000000000020FF};
`else
        tbl[0] = '{32'h00000000, 128'h112233445566778899AABBCCDDEE1122,
                   184'h0200000000112233445566778899AABBCCDDEE1122FF};
        tbl[1] = '{32'h00000010, {16{8'hA5}},
                   184'h0200000010A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5FF};
        tbl[2] = '{32'hDEADBEEF, 128'h0,
                   184'h02DEADBEEF00000000000000000000000000000000FF};
`endif

        rsp_if.rsp_valid = 1'b0;
        rsp_if.rsp_addr  = '0;
        rsp_if.rsp_data  = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_uart_tx", uart_tx, 1'b1);
        chk("rst_rsp_ready", rsp_if.rsp_ready, 1'b1);
        chk("rst_tx_busy", tx_busy, 1'b0);
        chk("rst_rsp_done", rsp_done, 1'b0);
        sys_rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            push_stream(tbl[i].stream, NB);
            send(tbl[i].addr, tbl[i].data);
            wait_idle();
        end

        // Valid held across two packets, inputs changed while the first is on the line
        a1 = $urandom; d1 = {$urandom, $urandom, $urandom, $urandom};
        a2 = $urandom; d2 = {$urandom, $urandom, $urandom, $urandom};
        push_model(a1, d1);
        rsp_if.rsp_valid = 1'b1;
        rsp_if.rsp_addr  = a1;
        rsp_if.rsp_data  = d1;
        @(posedge sys_clk); #1;
        repeat (3000) @(posedge sys_clk);
        #1;
        rsp_if.rsp_addr = a2;
        rsp_if.rsp_data = d2;
        push_model(a2, d2);
        t = 0;
        while (rsp_done !== 1'b1 && t < TMO) begin
            @(posedge sys_clk); #1;
            t++;
        end
        chk("b2b_done_seen", rsp_done, 1'b1);
        @(posedge sys_clk); #1;
        chk("b2b_second_accepted_ready", rsp_if.rsp_ready, 1'b0);
        chk("b2b_second_accepted_busy", tx_busy, 1'b1);
        rsp_if.rsp_valid = 1'b0;
        wait_idle();

        // Reset during data byte 7 aborts the packet with no completion pulse
        a1 = $urandom; d1 = {$urandom, $urandom, $urandom, $urandom};
        push_model(a1, d1);
        send(a1, d1);
        repeat (11 * FRAME_T + 300) @(posedge sys_clk);
        #3;
        sys_rst = 1'b1;
        exp_bytes.delete();
        exp_starts.delete();
        exp_done.delete();
        #1;
        chk("abort_uart_tx", uart_tx, 1'b1);
        chk("abort_tx_busy", tx_busy, 1'b0);
        chk("abort_rsp_ready", rsp_if.rsp_ready, 1'b1);
        chk("abort_rsp_done", rsp_done, 1'b0);
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        repeat (2000) @(posedge sys_clk);
        #1;

        a1 = $urandom; d1 = {$urandom, $urandom, $urandom, $urandom};
        push_model(a1, d1);
        send(a1, d1);
        wait_idle();
        repeat (20) @(posedge sys_clk);
        #1;

        chk("leftover_bytes", exp_bytes.size(), 0);
        chk("leftover_starts", exp_starts.size(), 0);
        chk("leftover_done", exp_done.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
